// File: rtl/motor_speed_pkg.sv
// Shared types for the motor speed ramp: per-channel regulation state encoding.
package motor_speed_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        IDLE   = 2'd0,
        ACCEL  = 2'd1,
        CRUISE = 2'd2,
        BRAKE  = 2'd3
    } ramp_state_t;

endpackage

// File: rtl/speed_ramp_ch.sv
// One channel: speed register ramping toward t_eff once per tick, with a regulation FSM.
// Speed/state update on the tick edge; estop forces 0/IDLE on any edge; no backpressure.
module speed_ramp_ch
    import motor_speed_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         estop,
    input  logic [W-1:0] t_eff,
    input  logic [W-1:0] accel_step,
    input  logic [W-1:0] brake_step,
    output logic [W-1:0] speed,
    output ramp_state_t  state,
    output logic         at_target
);

    logic [W-1:0] speed_nxt;
    ramp_state_t  state_nxt;
    logic [W:0]   sum_up;
    logic [W:0]   floor_dn;

    // Extra bit keeps the sums exact so the clamp compares never see a wrapped value.
    assign sum_up   = {1'b0, speed} + {1'b0, accel_step};
    assign floor_dn = {1'b0, t_eff} + {1'b0, brake_step};

    always_comb begin
        speed_nxt = speed;
        if (speed < t_eff) begin
            speed_nxt = (sum_up >= {1'b0, t_eff}) ? t_eff : sum_up[W-1:0];
        end else if (speed > t_eff) begin
            speed_nxt = ({1'b0, speed} <= floor_dn) ? t_eff : (speed - brake_step);
        end
    end

    always_comb begin
        state_nxt = IDLE;
        if (speed_nxt == t_eff) begin
            state_nxt = (t_eff == '0) ? IDLE : CRUISE;
        end else if (speed_nxt < t_eff) begin
            state_nxt = ACCEL;
        end else begin
            state_nxt = BRAKE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || estop) begin
            speed <= '0;
            state <= IDLE;
        end else if (tick) begin
            speed <= speed_nxt;
            state <= state_nxt;
        end
    end

    always_comb begin
        at_target = (state == CRUISE) || (state == IDLE);
    end

endmodule

// File: rtl/motor_speed_ramp.sv
// Multi-channel speed regulator: clamps each setpoint to MAX_SPEED and packs channel outputs.
// Outputs are the channel registers (one tick edge of latency); no backpressure.
module motor_speed_ramp
    import motor_speed_pkg::*;
#(
    parameter int W         = 8,
    parameter int NCH       = 2,
    parameter int MAX_SPEED = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              estop,
    input  logic [NCH-1:0]    en,
    input  logic [NCH*W-1:0]  target,
    input  logic [W-1:0]      accel_step,
    input  logic [W-1:0]      brake_step,
    output logic [NCH*W-1:0]  speed,
    output logic [NCH*ST_W-1:0] state,
    output logic [NCH-1:0]    at_target
);

    localparam logic [W-1:0] MAX_W = W'(MAX_SPEED);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [W-1:0] tgt;
        logic [W-1:0] t_eff;
        ramp_state_t  ch_state;

        assign tgt   = target[i*W +: W];
        // A disabled channel ramps down to zero rather than stopping abruptly.
        assign t_eff = !en[i] ? '0 : ((tgt > MAX_W) ? MAX_W : tgt);

        speed_ramp_ch #(.W(W)) u_ch (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick),
            .estop      (estop),
            .t_eff      (t_eff),
            .accel_step (accel_step),
            .brake_step (brake_step),
            .speed      (speed[i*W +: W]),
            .state      (ch_state),
            .at_target  (at_target[i])
        );

        assign state[i*ST_W +: ST_W] = ch_state;
    end

endmodule

// File: tb/tb_motor_speed_ramp.sv
// Directed-vector bench for motor_speed_ramp (W=8, NCH=2, MAX_SPEED=200).
module tb_motor_speed_ramp;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        estop;
    logic [1:0]  en;
    logic [15:0] target;
    logic [7:0]  accel_step;
    logic [7:0]  brake_step;
    logic [15:0] speed;
    logic [3:0]  state;
    logic [1:0]  at_target;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    motor_speed_ramp #(.W(8), .NCH(2), .MAX_SPEED(200)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .estop      (estop),
        .en         (en),
        .target     (target),
        .accel_step (accel_step),
        .brake_step (brake_step),
        .speed      (speed),
        .state      (state),
        .at_target  (at_target)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Channel c: expected speed, state, at_target.
    task automatic chk_ch(input string tag, input int c, input int sp, input int st);
        chk({tag, "_spd"}, int'(speed[c*8 +: 8]), sp);
        chk({tag, "_st"},  int'(state[c*2 +: 2]), st);
        chk({tag, "_at"},  int'(at_target[c]), (st == 0 || st == 2) ? 1 : 0);
    endtask

    // Inputs change on negedge; the tick is seen by exactly one posedge.
    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; estop = 1'b0; en = 2'b00;
        target = '0; accel_step = '0; brake_step = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1. reset state, ticks with en=0 are no-ops
        chk_ch("rst_c0", 0, 0, 0);
        chk_ch("rst_c1", 1, 0, 0);
        target = {8'd50, 8'd50}; accel_step = 8'd10;
        do_tick();
        do_tick();
        chk_ch("dis_c0", 0, 0, 0);
        chk_ch("dis_c1", 1, 0, 0);

        // 2. ch0 accelerates to cruise at 100
        en = 2'b01; target = {8'd0, 8'd100}; accel_step = 8'd10;
        for (int k = 1; k <= 10; k++) begin
            do_tick();
            chk_ch($sformatf("acc%0d", k), 0, 10 * k, (k < 10) ? 1 : 2);
        end

        // 3. brake with clamp at 35
        target[7:0] = 8'd35; brake_step = 8'd20;
        begin
            int exp_sp[4] = '{80, 60, 40, 35};
            int exp_st[4] = '{3, 3, 3, 2};
            for (int k = 0; k < 4; k++) begin
                do_tick();
                chk_ch($sformatf("brk%0d", k), 0, exp_sp[k], exp_st[k]);
            end
        end

        // 4. ch1 saturates at MAX_SPEED; ch0 holds
        en = 2'b11; target[15:8] = 8'd250; accel_step = 8'd30;
        for (int k = 1; k <= 7; k++) begin
            do_tick();
            chk_ch($sformatf("sat%0d", k), 1, (k < 7) ? 30 * k : 200, (k < 7) ? 1 : 2);
        end
        chk_ch("sat_c0", 0, 35, 2);
        do_tick();
        chk_ch("sat_hold", 1, 200, 2);

        // target change between ticks has no effect
        target[7:0] = 8'd100; accel_step = 8'd65;
        idle_cycle();
        chk_ch("no_tick", 0, 35, 2);
        do_tick();
        chk_ch("jump100", 0, 100, 2);

        // 5a. disable ch0: brakes down to 0 then IDLE
        en = 2'b10; brake_step = 8'd40;
        begin
            int exp_sp[3] = '{60, 20, 0};
            int exp_st[3] = '{3, 3, 0};
            for (int k = 0; k < 3; k++) begin
                do_tick();
                chk_ch($sformatf("off%0d", k), 0, exp_sp[k], exp_st[k]);
            end
        end
        chk_ch("off_c1", 1, 200, 2);

        // zero accel step: speed stays, state stays ACCEL
        en = 2'b11; target[7:0] = 8'd50; accel_step = 8'd0;
        do_tick();
        do_tick();
        chk_ch("zstep", 0, 0, 1);

        // 5b. estop mid-ramp at 70
        accel_step = 8'd10; target[7:0] = 8'd100;
        for (int k = 0; k < 7; k++) do_tick();
        chk_ch("pre_es", 0, 70, 1);
        estop = 1'b1;
        idle_cycle();
        chk_ch("es_c0", 0, 0, 0);
        chk_ch("es_c1", 1, 0, 0);
        do_tick();
        do_tick();
        chk_ch("es_hold", 0, 0, 0);
        estop = 1'b0;
        do_tick();
        chk_ch("es_rel_c0", 0, 10, 1);
        chk_ch("es_rel_c1", 1, 10, 1);
        // tick and estop in the same cycle: estop wins
        estop = 1'b1;
        do_tick();
        estop = 1'b0;
        chk_ch("es_tick", 0, 0, 0);

        // 6a. independence: ch0 accelerates while ch1 brakes
        target = {8'd200, 8'd100}; accel_step = 8'd100;
        do_tick();
        do_tick();
        chk_ch("ind_pre_c0", 0, 100, 2);
        chk_ch("ind_pre_c1", 1, 200, 2);
        target = {8'd100, 8'd150}; accel_step = 8'd10; brake_step = 8'd30;
        begin
            int e0[4] = '{110, 120, 130, 140};
            int e1[4] = '{170, 140, 110, 100};
            for (int k = 0; k < 4; k++) begin
                do_tick();
                chk_ch($sformatf("ind%0d_c0", k), 0, e0[k], 1);
                chk_ch($sformatf("ind%0d_c1", k), 1, e1[k], (k < 3) ? 3 : 2);
            end
        end

        // 6b. reset pulse mid-ramp
        rst = 1'b1;
        tick = 1'b1;
        idle_cycle();
        rst = 1'b0;
        tick = 1'b0;
        chk_ch("mrst_c0", 0, 0, 0);
        chk_ch("mrst_c1", 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
